// File: rtl/issue_pkg.sv
// -----------------------------------------------------------------------------
// issue_pkg
// Shared definitions for the in-order issue controller: architectural sizes,
// the issue FSM state type, the register index type and a one-hot decoder.
// -----------------------------------------------------------------------------
package issue_pkg;

    localparam int NREGS  = 16;
    localparam int RIDX_W = 4;
    localparam int PERF_W = 32;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } issue_state_e;

    typedef logic [RIDX_W-1:0] reg_idx_t;

    // One-hot of a register index, zero when the index is not valid.
    function automatic logic [NREGS-1:0] onehot(input reg_idx_t idx, input logic en);
        logic [NREGS-1:0] one;
        one = {{(NREGS-1){1'b0}}, 1'b1};
        return en ? (one << idx) : '0;
    endfunction

endpackage

// File: rtl/mod_issue_ctrl_if.sv
// -----------------------------------------------------------------------------
// issue_if
// Decode / execute / writeback / branch handshake bundle of the issue
// controller.
//   master : decode + execute side (drives the instruction, ex_ready,
//            writeback and branch outcome; receives id_ready / ex_issue)
//   slave  : mod_issue_ctrl
// -----------------------------------------------------------------------------
interface issue_if;
    import issue_pkg::*;

    logic             id_valid;
    logic [NREGS-1:0] id_src_mask;
    reg_idx_t         id_dst_a;
    logic             id_dst_a_vld;
    reg_idx_t         id_dst_b;
    logic             id_dst_b_vld;
    logic             id_uses_flags;
    logic             id_sets_flags;
    logic             id_is_branch;
    logic             id_ready;

    logic             ex_ready;
    logic             ex_issue;

    logic             wb_valid;
    reg_idx_t         wb_dst_a;
    logic             wb_dst_a_vld;
    reg_idx_t         wb_dst_b;
    logic             wb_dst_b_vld;
    logic             wb_flags;

    logic             br_resolve;
    logic             br_taken;

    modport master (
        output id_valid, id_src_mask, id_dst_a, id_dst_a_vld, id_dst_b, id_dst_b_vld,
               id_uses_flags, id_sets_flags, id_is_branch, ex_ready,
               wb_valid, wb_dst_a, wb_dst_a_vld, wb_dst_b, wb_dst_b_vld, wb_flags,
               br_resolve, br_taken,
        input  id_ready, ex_issue
    );

    modport slave (
        input  id_valid, id_src_mask, id_dst_a, id_dst_a_vld, id_dst_b, id_dst_b_vld,
               id_uses_flags, id_sets_flags, id_is_branch, ex_ready,
               wb_valid, wb_dst_a, wb_dst_a_vld, wb_dst_b, wb_dst_b_vld, wb_flags,
               br_resolve, br_taken,
        output id_ready, ex_issue
    );

endinterface

// File: rtl/mod_scoreboard.sv
// -----------------------------------------------------------------------------
// mod_scoreboard
// Register busy vector plus flags-busy bit.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   set_mask_i        registers becoming busy (issuing instruction)
//   clr_mask_i        registers retiring this cycle
//   flag_set_i        issuing instruction writes flags
//   flag_clr_i        flag-writing instruction retires
//   sb_o / flags_o    registered busy state
//   sb_eff_o          busy vector with this cycle's retirements removed
//   flags_eff_o       flags-busy with this cycle's retirement removed
// Set beats clear when both hit the same bit in one cycle.
// -----------------------------------------------------------------------------
module mod_scoreboard
    import issue_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [NREGS-1:0] set_mask_i,
    input  logic [NREGS-1:0] clr_mask_i,
    input  logic             flag_set_i,
    input  logic             flag_clr_i,
    output logic [NREGS-1:0] sb_o,
    output logic [NREGS-1:0] sb_eff_o,
    output logic             flags_o,
    output logic             flags_eff_o
);

    logic [NREGS-1:0] sb_q, sb_d;
    logic             flags_q, flags_d;

    // Retirements are visible to the hazard check in the same cycle.
    assign sb_eff_o    = sb_q & ~clr_mask_i;
    assign flags_eff_o = flags_q & ~flag_clr_i;

    assign sb_d    = sb_eff_o | set_mask_i;
    assign flags_d = flags_eff_o | flag_set_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_q    <= '0;
            flags_q <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            flags_q <= flags_d;
        end
    end

    assign sb_o    = sb_q;
    assign flags_o = flags_q;

endmodule

// File: rtl/mod_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mod_issue_ctrl
// In-order issue controller between decode and execute. Resolves register
// (RAW/WAW) and flag hazards against the scoreboard, holds issue while a
// conditional jump is unresolved and pulses a one-cycle flush when it is taken.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   bus (slave)      decode/execute/writeback/branch handshake (issue_if)
//   flush            registered one-cycle discard of fetch/decode
//   score_board      registered register busy bits
//   flags_busy       registered flags busy bit
//   perf_*           issue / hazard-stall / branch-stall counters
// Configuration: define ISSUE_PERF_EN to build the performance counters;
// otherwise the perf ports are tied to zero.
// -----------------------------------------------------------------------------
module mod_issue_ctrl
    import issue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    issue_if.slave            bus,
    output logic              flush,
    output logic [NREGS-1:0]  score_board,
    output logic              flags_busy,
    output logic [PERF_W-1:0] perf_issue,
    output logic [PERF_W-1:0] perf_stall_haz,
    output logic [PERF_W-1:0] perf_stall_br
);

    issue_state_e     state_q, state_d;
    logic             flush_q;
    logic [NREGS-1:0] clr_mask, set_mask, sb_eff;
    logic             flags_eff;
    logic             hazard, ready, issue;

    assign clr_mask = bus.wb_valid ? (onehot(bus.wb_dst_a, bus.wb_dst_a_vld) |
                                      onehot(bus.wb_dst_b, bus.wb_dst_b_vld)) : '0;

    // Equal destinations collapse into the same bit of the OR.
    assign set_mask = issue ? (onehot(bus.id_dst_a, bus.id_dst_a_vld) |
                               onehot(bus.id_dst_b, bus.id_dst_b_vld)) : '0;

    mod_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .set_mask_i  (set_mask),
        .clr_mask_i  (clr_mask),
        .flag_set_i  (issue & bus.id_sets_flags),
        .flag_clr_i  (bus.wb_flags),
        .sb_o        (score_board),
        .sb_eff_o    (sb_eff),
        .flags_o     (flags_busy),
        .flags_eff_o (flags_eff)
    );

    assign hazard = (|(bus.id_src_mask & sb_eff))
                  | (bus.id_dst_a_vld & sb_eff[bus.id_dst_a])
                  | (bus.id_dst_b_vld & sb_eff[bus.id_dst_b])
                  | ((bus.id_uses_flags | bus.id_sets_flags) & flags_eff);

    // Readiness is independent of id_valid and forced low during reset.
    assign ready        = ~reset & (state_q == RUN) & bus.ex_ready & ~hazard;
    assign issue        = bus.id_valid & ready;
    assign bus.id_ready = ready;
    assign bus.ex_issue = issue;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (issue && bus.id_is_branch) state_d = BR_WAIT;
            BR_WAIT: if (bus.br_resolve)            state_d = bus.br_taken ? FLUSH : RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= (state_d == FLUSH);
        end
    end

    assign flush = flush_q;

`ifdef ISSUE_PERF_EN
    logic [PERF_W-1:0] perf_issue_q, perf_haz_q, perf_br_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue_q <= '0;
            perf_haz_q   <= '0;
            perf_br_q    <= '0;
        end else begin
            if (issue)
                perf_issue_q <= perf_issue_q + 1'b1;
            if (bus.id_valid && state_q == RUN && bus.ex_ready && hazard)
                perf_haz_q <= perf_haz_q + 1'b1;
            if (bus.id_valid && state_q != RUN)
                perf_br_q <= perf_br_q + 1'b1;
        end
    end

    assign perf_issue     = perf_issue_q;
    assign perf_stall_haz = perf_haz_q;
    assign perf_stall_br  = perf_br_q;
`else
    assign perf_issue     = '0;
    assign perf_stall_haz = '0;
    assign perf_stall_br  = '0;
`endif

endmodule
